// File: rtl/scan_sel_seq_pkg.sv
// Shared types and sizes for the channel-scan sequencer.
// State encodings are fixed so they stay stable in debug dumps.
package scan_sel_seq_pkg;

   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      FIN  = 2'd2
   } state_e;

endpackage

// File: rtl/scan_next_ch.sv
// Combinational channel search.
// With first_i set it returns the lowest enabled channel; otherwise it returns the next
// enabled channel above cur_i, wrapping to the lowest one when nothing lies above.
module scan_next_ch
   import scan_sel_seq_pkg::*;
(
   input  logic [NUM_CH-1:0] mask_i,
   input  logic [SEL_W-1:0]  cur_i,
   input  logic              first_i,
   output logic [SEL_W-1:0]  nxt_o,
   output logic              found_above_o,
   output logic              any_o
);

   logic [SEL_W-1:0] lowest;
   logic [SEL_W-1:0] above;
   logic             found;

   // Descending scan: the last hit written is the lowest qualifying index.
   always_comb begin
      lowest = '0;
      above  = '0;
      found  = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            lowest = SEL_W'(i);
            if (!first_i && (i > int'(cur_i))) begin
               above = SEL_W'(i);
               found = 1'b1;
            end
         end
      end
   end

   assign nxt_o         = found ? above : lowest;
   assign found_above_o = found;
   assign any_o         = |mask_i;

endmodule

// File: rtl/scan_sel_seq.sv
// Channel-scan sequencer feeding a 3-to-8 decoder: walks the enabled channels of a
// latched mask, holding each for dwell+1 cycles, in one-shot or continuous mode.
module scan_sel_seq
   import scan_sel_seq_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               one_shot_i,
   input  logic [DWELL_W-1:0] dwell_i,
   input  logic [NUM_CH-1:0]  ch_mask_i,
   output logic               sel_a_o,
   output logic               sel_b_o,
   output logic               sel_c_o,
   output logic               sel_valid_o,
   output logic               ch_strobe_o,
   output logic               busy_o,
   output logic               done_o
);

   state_e             state_q;
   logic [SEL_W-1:0]   sel_q;
   logic               valid_q, strobe_q, busy_q, done_q;
   logic               stop_pend_q, one_shot_q;
   logic [DWELL_W-1:0] cnt_q, dwell_q;
   logic [NUM_CH-1:0]  mask_q;

   logic               in_idle;
   logic [NUM_CH-1:0]  srch_mask;
   logic [SEL_W-1:0]   nxt;
   logic               found_above, any;
   logic               last_cyc, end_scan;

   // One search instance serves both lookups: the live mask in IDLE, the latched one in SCAN.
   assign in_idle   = (state_q == IDLE);
   assign srch_mask = in_idle ? ch_mask_i : mask_q;

   scan_next_ch u_next (
      .mask_i        (srch_mask),
      .cur_i         (sel_q),
      .first_i       (in_idle),
      .nxt_o         (nxt),
      .found_above_o (found_above),
      .any_o         (any)
   );

   assign last_cyc = (cnt_q == dwell_q);
   assign end_scan = stop_pend_q | stop_i | (!found_above & one_shot_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         valid_q     <= 1'b0;
         strobe_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         one_shot_q  <= 1'b0;
         cnt_q       <= '0;
         dwell_q     <= '0;
         mask_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q   <= 1'b0;
               strobe_q <= 1'b0;
               if (start_i) begin
                  mask_q      <= ch_mask_i;
                  dwell_q     <= dwell_i;
                  one_shot_q  <= one_shot_i;
                  cnt_q       <= '0;
                  stop_pend_q <= 1'b0;
                  if (any) begin
                     state_q  <= SCAN;
                     sel_q    <= nxt;
                     valid_q  <= 1'b1;
                     strobe_q <= 1'b1;
                     busy_q   <= 1'b1;
                  end else begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (stop_i) stop_pend_q <= 1'b1;
               if (last_cyc) begin
                  cnt_q <= '0;
                  if (end_scan) begin
                     state_q  <= FIN;
                     sel_q    <= '0;
                     valid_q  <= 1'b0;
                     strobe_q <= 1'b0;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                  end else begin
                     sel_q    <= nxt;
                     strobe_q <= 1'b1;
                  end
               end else begin
                  cnt_q    <= cnt_q + 1'b1;
                  strobe_q <= 1'b0;
               end
            end
            FIN: begin
               state_q     <= IDLE;
               done_q      <= 1'b0;
               stop_pend_q <= 1'b0;
            end
            default: begin
               state_q  <= IDLE;
               sel_q    <= '0;
               valid_q  <= 1'b0;
               strobe_q <= 1'b0;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
            end
         endcase
      end
   end

   assign sel_a_o     = sel_q[2];
   assign sel_b_o     = sel_q[1];
   assign sel_c_o     = sel_q[0];
   assign sel_valid_o = valid_q;
   assign ch_strobe_o = strobe_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_scan_sel_seq.sv
// Directed vector bench for scan_sel_seq: per-cycle table of inputs and expected outputs,
// plus hand-written sequences for reset, long dwell and mid-scan async reset.
module tb_scan_sel_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, stop = 1'b0, one_shot = 1'b0;
   logic [7:0] dwell = '0, ch_mask = '0;
   logic       sel_a, sel_b, sel_c, sel_valid, ch_strobe, busy, done;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   scan_sel_seq #(.DWELL_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .one_shot_i(one_shot),
      .dwell_i(dwell), .ch_mask_i(ch_mask), .sel_a_o(sel_a), .sel_b_o(sel_b), .sel_c_o(sel_c),
      .sel_valid_o(sel_valid), .ch_strobe_o(ch_strobe), .busy_o(busy), .done_o(done)
   );

   // Expected flags are {sel_valid, ch_strobe, busy, done}.
   localparam logic [3:0] S = 4'b1110;  // first cycle of a channel
   localparam logic [3:0] H = 4'b1010;  // holding a channel
   localparam logic [3:0] D = 4'b0001;  // done pulse
   localparam logic [3:0] Z = 4'b0000;  // idle

   typedef struct {
      logic       st, sp, os;
      logic [7:0] dw, mk;
      logic [2:0] sel;
      logic [3:0] fl;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic st, logic sp, logic os, logic [7:0] dw, logic [7:0] m,
                               logic [2:0] sel, logic [3:0] fl);
      vec_t v;
      v.st = st; v.sp = sp; v.os = os; v.dw = dw; v.mk = m; v.sel = sel; v.fl = fl;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, logic [2:0] esel, logic [3:0] efl);
      logic [6:0] act, exp;
      act = {sel_a, sel_b, sel_c, sel_valid, ch_strobe, busy, done};
      exp = {esel, efl};
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got sel/v/s/b/d=%b required %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_vecs(string name, int lo, int hi);
      for (int i = lo; i < hi; i++) begin
         start = vecs[i].st; stop = vecs[i].sp; one_shot = vecs[i].os;
         dwell = vecs[i].dw; ch_mask = vecs[i].mk;
         tick();
         check($sformatf("%s[%0d]", name, i - lo), vecs[i].sel, vecs[i].fl);
      end
      start = 1'b0; stop = 1'b0;
   endtask

   int t2, t3, t4, t4b, t4c, t5, tend;

   initial begin
      // full mask, dwell 0, one-shot
      t2 = vecs.size();
      vecs.push_back(mk(1, 0, 1, 8'd0, 8'hFF, 3'd0, S));
      for (int c = 1; c < 8; c++) vecs.push_back(mk(0, 0, 1, 8'd0, 8'hFF, 3'(c), S));
      vecs.push_back(mk(0, 0, 1, 8'd0, 8'hFF, 3'd0, D));
      vecs.push_back(mk(0, 0, 1, 8'd0, 8'hFF, 3'd0, Z));
      // sparse mask, dwell 2, one-shot: channels 2, 5, 7
      t3 = vecs.size();
      vecs.push_back(mk(1, 0, 1, 8'd2, 8'hA4, 3'd2, S));
      vecs.push_back(mk(0, 0, 1, 8'd2, 8'hA4, 3'd2, H));
      vecs.push_back(mk(0, 0, 1, 8'd2, 8'hA4, 3'd2, H));
      vecs.push_back(mk(0, 0, 1, 8'd2, 8'hA4, 3'd5, S));
      vecs.push_back(mk(0, 0, 1, 8'd2, 8'hA4, 3'd5, H));
      vecs.push_back(mk(0, 0, 1, 8'd2, 8'hA4, 3'd5, H));
      vecs.push_back(mk(0, 0, 1, 8'd2, 8'hA4, 3'd7, S));
      vecs.push_back(mk(0, 0, 1, 8'd2, 8'hA4, 3'd7, H));
      vecs.push_back(mk(0, 0, 1, 8'd2, 8'hA4, 3'd7, H));
      vecs.push_back(mk(0, 0, 1, 8'd2, 8'hA4, 3'd0, D));
      vecs.push_back(mk(0, 0, 1, 8'd2, 8'hA4, 3'd0, Z));
      // mask 81 continuous, stop sampled at end of first channel-7 cycle
      t4 = vecs.size();
      vecs.push_back(mk(1, 0, 0, 8'd1, 8'h81, 3'd0, S));
      vecs.push_back(mk(0, 0, 0, 8'd1, 8'h81, 3'd0, H));
      vecs.push_back(mk(0, 0, 0, 8'd1, 8'h81, 3'd7, S));
      vecs.push_back(mk(0, 0, 0, 8'd1, 8'h81, 3'd7, H));
      vecs.push_back(mk(0, 0, 0, 8'd1, 8'h81, 3'd0, S));
      vecs.push_back(mk(0, 0, 0, 8'd1, 8'h81, 3'd0, H));
      vecs.push_back(mk(0, 0, 0, 8'd1, 8'h81, 3'd7, S));
      vecs.push_back(mk(0, 1, 0, 8'd1, 8'h81, 3'd7, H));
      vecs.push_back(mk(0, 0, 0, 8'd1, 8'h81, 3'd0, D));
      vecs.push_back(mk(0, 0, 0, 8'd1, 8'h81, 3'd0, Z));
      // single-bit mask continuous repeats; stop on a last dwell cycle ends at once
      t4b = vecs.size();
      vecs.push_back(mk(1, 0, 0, 8'd0, 8'h08, 3'd3, S));
      vecs.push_back(mk(0, 0, 0, 8'd0, 8'h08, 3'd3, S));
      vecs.push_back(mk(0, 0, 0, 8'd0, 8'h08, 3'd3, S));
      vecs.push_back(mk(0, 1, 0, 8'd0, 8'h08, 3'd0, D));
      vecs.push_back(mk(0, 1, 0, 8'd0, 8'h08, 3'd0, Z));
      vecs.push_back(mk(0, 0, 0, 8'd0, 8'h08, 3'd0, Z));
      // mask 80: top channel first, one-shot
      t4c = vecs.size();
      vecs.push_back(mk(1, 0, 1, 8'd0, 8'h80, 3'd7, S));
      vecs.push_back(mk(0, 0, 1, 8'd0, 8'h80, 3'd0, D));
      vecs.push_back(mk(0, 0, 1, 8'd0, 8'h80, 3'd0, Z));
      // empty mask, then sparse rerun with start/config noise mid-scan and in FIN
      t5 = vecs.size();
      vecs.push_back(mk(1, 0, 1, 8'd2, 8'h00, 3'd0, D));
      vecs.push_back(mk(0, 0, 1, 8'd2, 8'h00, 3'd0, Z));
      vecs.push_back(mk(1, 0, 1, 8'd2, 8'hA4, 3'd2, S));
      vecs.push_back(mk(1, 0, 0, 8'd0, 8'hFF, 3'd2, H));
      vecs.push_back(mk(0, 0, 0, 8'd0, 8'h01, 3'd2, H));
      vecs.push_back(mk(1, 0, 0, 8'd7, 8'hFF, 3'd5, S));
      vecs.push_back(mk(0, 0, 0, 8'd0, 8'h00, 3'd5, H));
      vecs.push_back(mk(1, 0, 0, 8'd0, 8'h00, 3'd5, H));
      vecs.push_back(mk(0, 0, 0, 8'd0, 8'h02, 3'd7, S));
      vecs.push_back(mk(1, 0, 0, 8'd0, 8'h02, 3'd7, H));
      vecs.push_back(mk(0, 0, 0, 8'd0, 8'h02, 3'd7, H));
      vecs.push_back(mk(1, 0, 0, 8'd0, 8'h02, 3'd0, D));
      vecs.push_back(mk(1, 0, 0, 8'd0, 8'h02, 3'd0, Z));
      vecs.push_back(mk(0, 0, 0, 8'd0, 8'h02, 3'd0, Z));
      tend = vecs.size();

      // reset state and idle with no start
      #2;
      check("reset_low", 3'd0, Z);
      tick();
      check("reset_held", 3'd0, Z);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("idle_%0d", i), 3'd0, Z);
      end

      run_vecs("full_mask", t2, t3);
      run_vecs("sparse", t3, t4);
      run_vecs("stop_ch7", t4, t4b);
      run_vecs("single_bit", t4b, t4c);
      run_vecs("mask80", t4c, t5);
      run_vecs("empty_busy", t5, tend);

      // dwell all-ones: 256 valid cycles on one channel, one strobe, then done
      begin
         int nv, ns, g;
         bit seen_done;
         nv = 0; ns = 0; seen_done = 0;
         start = 1'b1; one_shot = 1'b1; dwell = 8'hFF; ch_mask = 8'h01;
         tick();
         start = 1'b0;
         for (g = 0; g < 400 && !seen_done; g++) begin
            if (done) seen_done = 1;
            else begin
               if (sel_valid) nv++;
               if (ch_strobe) ns++;
               tick();
            end
         end
         n_cmp++;
         if (!seen_done || nv != 256 || ns != 1) begin
            n_fail++;
            $display("FAIL long_dwell: done=%0d valid=%0d strobes=%0d required done=1 valid=256 strobes=1",
                     seen_done, nv, ns);
         end
         tick();
         check("long_dwell_idle", 3'd0, Z);
      end

      // async reset in the first cycle of channel 5, then a fresh full-mask scan
      start = 1'b1; one_shot = 1'b1; dwell = 8'd2; ch_mask = 8'hA4;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      check("pre_reset_ch5", 3'd5, S);
      #2 rst_n = 1'b0;
      #1 check("async_reset", 3'd0, Z);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("reset_nodone_%0d", i), 3'd0, Z);
      end
      #2 rst_n = 1'b1;
      tick();
      check("post_reset_idle", 3'd0, Z);
      run_vecs("fresh_full", t2, t3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
